mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-port coefficient/sample memory that feeds the MAC datapath. Port 0 serves the accumulation controller (read address stream); port 1 serves the host loader (reads and writes). It grants ownership per burst, multiplexes the winner onto the memory port, and routes read data back with a per-port valid strobe one cycle later.

## Interface
- ADDR_W, 6, memory address width ({u,v} address space, 64 words)
- DATA_W, 16, memory data width
- MAX_BURST, 8, max consecutive beats for one owner while the other port is requesting (≥1)

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Req0, Req1  in  1  access request; held with a valid Addr/We/WData until the access is granted
- Addr0, Addr1  in  ADDR_W  access address
- We0, We1  in  1  1 = write, 0 = read
- WData0, WData1  in  DATA_W  write data
- Gnt0, Gnt1  out  1  access accepted this cycle (one beat)
- RValid0, RValid1  out  1  RData holds this port's read data
- RData  out  DATA_W  shared read-return bus (= Mem_RData)
- Mem_En, Mem_We  out  1  memory enable / write enable
- Mem_Addr  out  ADDR_W  memory address
- Mem_WData  out  DATA_W  memory write data
- Mem_RData  in  DATA_W  memory read data, valid 1 cycle after a read enable
- Busy  out  1  State != IDLE

## Operation
- FSM states: IDLE, OWN0, OWN1; registers State, Last_Owner (1 bit), Beat (counts 0..MAX_BURST-1), RValid0/1.
- IDLE: no grants. If exactly one Req is high, go to OWN of that port. If both are high, go to OWN of the port != Last_Owner. Entering OWNi: Beat <= 0, Last_Owner <= i.
- OWNi: Gnt_i = Req_i (combinational); Gnt_j = 0. Each granted beat increments Beat.
- OWNi exit:
  - Req_i = 0 → OWNj if Req_j, else IDLE.
  - Beat == MAX_BURST-1, Gnt_i, and Req_j → OWNj (no bubble).
  - Otherwise stay in OWNi. Beat saturates at MAX_BURST-1 while no other request is pending.
- Memory mux (combinational): Mem_En = Gnt0|Gnt1. Mem_We, Mem_Addr and Mem_WData come from the owning port; they are 0 when no grant is active.
- Read return: RValid_i <= Gnt_i & ~We_i; RData = Mem_RData. Writes produce no RValid.
- Both ports request in the same cycle from IDLE → exactly one port is granted; no simultaneous grants, ever.
- Owner drops Req in the same cycle the limit is reached → the Req_i = 0 rule applies.

## Timing
- Reset values: State = IDLE, Last_Owner = 1 (port 0 wins the first tie), Beat = 0. All outputs are 0: Gnt0/1, RValid0/1, Mem_En, Mem_We, Mem_Addr, Mem_WData, Busy. RData follows Mem_RData.
- Reset asserted mid-burst: ownership is lost immediately and pending RValid is discarded. Requesters must re-request after reset deasserts.
- Arbitration latency from IDLE: Req rises in cycle N; first Gnt in cycle N+1.
- Ownership handover (OWN→OWN): 0 bubble cycles. Return to IDLE then to a new request costs 1 cycle.
- Read latency: Gnt in cycle N → RValid and RData in cycle N+1.
- Sustained throughput: 1 beat per cycle while the owner holds Req.

## Configuration
- ARB_ROUND_ROBIN_EN defined: ties in IDLE resolve by Last_Owner (round robin), and the MAX_BURST limit forces handover.
- Undefined: fixed priority. Port 0 wins every IDLE tie, the burst limit is disabled, and the owner keeps the port until it drops Req. Beat is still counted but does not affect state.

## Test plan
- Reset: drive Reset = 0 with Req0 = Req1 = 1 → all outputs 0 and Busy = 0. Release reset → Gnt0 = 1 in the next cycle.
- Single read: Req0 = 1, Addr0 = 6'h2A, We0 = 0 for one beat. Memory holds 16'h1234 at 6'h2A → Mem_Addr = 6'h2A during Gnt0, then RValid0 = 1 and RData = 16'h1234 one cycle later, with RValid1 = 0.
- Write then read on port 1: write 16'hBEEF to 6'h05, then read 6'h05 → RValid1 with RData = 16'hBEEF. No RValid on the write beat.
- Round robin (macro on, MAX_BURST = 8): Req0 held streaming addresses 0..63, Req1 raised at cycle 3 → exactly 8 Gnt0 beats, then Gnt1 with no bubble cycle. Port 0 resumes once Req1 drops.
- Fixed priority (macro off): same stimulus → Gnt0 for all 64 beats, and Gnt1 only after Req0 falls.
- Reset mid-burst: assert Reset during a read grant → the next-cycle RValid0 = 0 and State = IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter for the single-port coefficient/sample memory that
//   feeds the MAC datapath. Ownership is granted per burst; the owner's request
//   fields are multiplexed onto the memory port and read data is returned with
//   a per-port valid strobe one cycle after the granted read.
//
//   Port 0: accumulation controller (read address stream)
//   Port 1: host loader (reads and writes)
//
// Build option:
//   ARB_ROUND_ROBIN_EN defined   : IDLE ties go to the port that did not own
//                                  last; MAX_BURST beats force a handover when
//                                  the other port is waiting.
//   ARB_ROUND_ROBIN_EN undefined : fixed priority; port 0 wins every IDLE tie
//                                  and the owner keeps the memory until it
//                                  drops its request.
//
// Ports:
//   Clock            in   system clock, rising edge
//   Reset            in   asynchronous active-low reset
//   Req0/1           in   access request, held with Addr/We/WData until granted
//   Addr0/1          in   access address
//   We0/1            in   1 = write, 0 = read
//   WData0/1         in   write data
//   Gnt0/1           out  beat accepted this cycle
//   RValid0/1        out  RData carries this port's read data
//   RData            out  shared read-return bus (Mem_RData passed through)
//   Mem_En/Mem_We    out  memory enable / write enable
//   Mem_Addr         out  memory address
//   Mem_WData        out  memory write data
//   Mem_RData        in   memory read data, valid one cycle after a read
//   Busy             out  arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic              We0,
  input  logic              We1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Busy
);

  // state | meaning
  // ------+---------------------------------------------------------------
  // IDLE  | nobody owns the memory; no grants, arbitrate pending requests
  // OWN0  | port 0 owns the memory; Gnt0 follows Req0
  // OWN1  | port 1 owns the memory; Gnt1 follows Req1

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state;
  logic                last_owner;
  logic [BEAT_W-1:0]   beat;

  logic                tie_to_0;
  logic                burst_done;

  // Grants are combinational so a held request gets one beat per cycle.
  assign Gnt0 = (state == OWN0) & Req0;
  assign Gnt1 = (state == OWN1) & Req1;

  // On an IDLE tie port 0 wins unless it was the last owner (round robin),
  // or always (fixed priority).
  assign tie_to_0   = RR_EN ? last_owner : 1'b1;

  // Only meaningful in round-robin builds; beat still counts otherwise.
  assign burst_done = RR_EN & (beat == BEAT_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat       <= '0;
      RValid0    <= 1'b0;
      RValid1    <= 1'b0;
    end else begin
      RValid0 <= Gnt0 & ~We0;
      RValid1 <= Gnt1 & ~We1;

      case (state)
        IDLE: begin
          if (Req0 && (!Req1 || tie_to_0)) begin
            state      <= OWN0;
            beat       <= '0;
            last_owner <= 1'b0;
          end else if (Req1) begin
            state      <= OWN1;
            beat       <= '0;
            last_owner <= 1'b1;
          end
        end

        OWN0: begin
          if (!Req0) begin
            if (Req1) begin
              state      <= OWN1;
              beat       <= '0;
              last_owner <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (burst_done && Req1) begin
            // Limit reached on this granted beat: hand over without a bubble.
            state      <= OWN1;
            beat       <= '0;
            last_owner <= 1'b1;
          end else if (beat != BEAT_LAST) begin
            beat <= beat + 1'b1;
          end
        end

        OWN1: begin
          if (!Req1) begin
            if (Req0) begin
              state      <= OWN0;
              beat       <= '0;
              last_owner <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_done && Req0) begin
            state      <= OWN0;
            beat       <= '0;
            last_owner <= 1'b0;
          end else if (beat != BEAT_LAST) begin
            beat <= beat + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port mux; everything but Mem_En is forced to zero without a grant.
  always_comb begin
    Mem_We    = 1'b0;
    Mem_Addr  = '0;
    Mem_WData = '0;
    if (Gnt0) begin
      Mem_We    = We0;
      Mem_Addr  = Addr0;
      Mem_WData = WData0;
    end else if (Gnt1) begin
      Mem_We    = We1;
      Mem_Addr  = Addr1;
      Mem_WData = WData1;
    end
  end

  assign Mem_En = Gnt0 | Gnt1;
  assign RData  = Mem_RData;
  assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Per-port drivers feed transaction queues
//   onto the request ports; a monitor predicts grants, the memory bus and read
//   returns from an arbitration model and a shadow memory, and compares every
//   cycle on the falling clock edge. Honours ARB_ROUND_ROBIN_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 8;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    int                gap;
  } txn_t;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              preload = 1'b1;

  logic              req_d   [2] = '{1'b0, 1'b0};
  logic [ADDR_W-1:0] addr_d  [2] = '{'0, '0};
  logic              we_d    [2] = '{1'b0, 1'b0};
  logic [DATA_W-1:0] wdata_d [2] = '{'0, '0};

  logic              Gnt0, Gnt1, RValid0, RValid1;
  logic [DATA_W-1:0] RData;
  logic              Mem_En, Mem_We, Busy;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData = '0;

  int vectors     = 0;
  int miscompares = 0;

  txn_t q0[$];
  txn_t q1[$];
  txn_t pend   [2];
  bit   pend_v [2] = '{1'b0, 1'b0};

  always #5 Clock = ~Clock;

  mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req0     (req_d[0]),
    .Req1     (req_d[1]),
    .Addr0    (addr_d[0]),
    .Addr1    (addr_d[1]),
    .We0      (we_d[0]),
    .We1      (we_d[1]),
    .WData0   (wdata_d[0]),
    .WData1   (wdata_d[1]),
    .Gnt0     (Gnt0),
    .Gnt1     (Gnt1),
    .RValid0  (RValid0),
    .RValid1  (RValid1),
    .RData    (RData),
    .Mem_En   (Mem_En),
    .Mem_We   (Mem_We),
    .Mem_Addr (Mem_Addr),
    .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData),
    .Busy     (Busy)
  );

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 42) return 16'h1234;
    return 16'(i * 16'h0321 + 16'h00A5);
  endfunction

  // Single-port RAM behind the arbiter, one-cycle read latency.
  logic [DATA_W-1:0] mem_env [64];
  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem_env[i] <= init_word(i);
    end else if (Mem_En) begin
      if (Mem_We) mem_env[Mem_Addr] <= Mem_WData;
      else        Mem_RData <= mem_env[Mem_Addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step_port(input int p, input logic granted);
    if (req_d[p] && granted) req_d[p] = 1'b0;
    if (!req_d[p]) begin
      if (!pend_v[p]) begin
        if (p == 0 && q0.size() > 0) begin
          pend[0] = q0.pop_front(); pend_v[0] = 1'b1;
        end else if (p == 1 && q1.size() > 0) begin
          pend[1] = q1.pop_front(); pend_v[1] = 1'b1;
        end
      end
      if (pend_v[p] && pend[p].gap == 0) begin
        req_d[p]   = 1'b1;
        addr_d[p]  = pend[p].addr;
        we_d[p]    = pend[p].we;
        wdata_d[p] = pend[p].wdata;
        pend_v[p]  = 1'b0;
      end else begin
        if (pend_v[p]) pend[p].gap = pend[p].gap - 1;
        // Idle ports present junk fields; the mux must ignore them.
        addr_d[p]  = ADDR_W'($urandom);
        we_d[p]    = 1'($urandom);
        wdata_d[p] = DATA_W'($urandom);
      end
    end
  endtask

  initial begin
    logic sg0, sg1;
    forever begin
      @(negedge Clock);
      sg0 = Gnt0;
      sg1 = Gnt1;
      @(posedge Clock);
      #1;
      step_port(0, sg0);
      step_port(1, sg1);
    end
  end

  // --------------------------------------------------------------- monitor
  initial begin
    logic [DATA_W-1:0] shadow [64];
    exp_t expq[$];
    exp_t e;
    int   owner, run, last, o, p;
    logic r0, r1, ro, rp, g0, g1;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ewe;

    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    owner = -1; run = 0; last = 1;

    forever begin
      @(negedge Clock);
      if (!Reset) begin
        chk("reset_outputs",
            {Gnt0, Gnt1, RValid0, RValid1, Mem_En, Mem_We, Busy, Mem_Addr, Mem_WData}, '0);
        expq.delete();
        owner = -1; run = 0; last = 1;
      end else begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("rvalid", {RValid0, RValid1}, (e.port == 0) ? 2'b10 : 2'b01);
          chk("rdata", RData, e.data);
        end else begin
          chk("rvalid_idle", {RValid0, RValid1}, 2'b00);
        end
        chk("busy", Busy, (owner != -1));

        r0 = req_d[0]; r1 = req_d[1];
        g0 = 1'b0;     g1 = 1'b0;
        if (owner == -1) begin
          if (r0 || r1) begin
            if (r0 && r1) owner = RR ? ((last == 0) ? 1 : 0) : 0;
            else          owner = r0 ? 0 : 1;
            run  = 0;
            last = owner;
          end
        end else begin
          o  = owner;
          p  = 1 - o;
          ro = (o == 0) ? r0 : r1;
          rp = (o == 0) ? r1 : r0;
          if (o == 0) g0 = ro; else g1 = ro;
          if (!ro) begin
            if (rp) begin owner = p; run = 0; last = p; end
            else owner = -1;
          end else begin
            run++;
            if (RR && run >= MAX_BURST && rp) begin owner = p; run = 0; last = p; end
          end
        end
        chk("grant", {Gnt0, Gnt1}, {g0, g1});

        ea = '0; ed = '0; ewe = 1'b0;
        if (g0)      begin ea = addr_d[0]; ed = wdata_d[0]; ewe = we_d[0]; end
        else if (g1) begin ea = addr_d[1]; ed = wdata_d[1]; ewe = we_d[1]; end
        chk("mem_bus", {Mem_En, Mem_We, Mem_Addr, Mem_WData}, {g0 | g1, ewe, ea, ed});

        if (g0 || g1) begin
          if (ewe) shadow[ea] = ed;
          else begin
            e.port = g0 ? 0 : 1;
            e.data = shadow[ea];
            expq.push_back(e);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------ main
  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !pend_v[0] && !pend_v[1] &&
             !req_d[0] && !req_d[1]) && k < budget) begin
      @(posedge Clock);
      k++;
    end
    chk(nm, (k < budget), 1'b1);
    repeat (3) @(posedge Clock);
    #2;
  endtask

  task automatic push(input int p, input logic [ADDR_W-1:0] a, input logic w,
                      input logic [DATA_W-1:0] d, input int g);
    txn_t t;
    t.addr = a; t.we = w; t.wdata = d; t.gap = g;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  initial begin
    int n0, k;
    bit hit;

    // Both ports requesting while held in reset.
    push(0, 6'h2A, 1'b0, '0, 0);
    push(1, 6'h05, 1'b1, 16'hBEEF, 0);
    push(1, 6'h05, 1'b0, '0, 0);
    repeat (3) @(posedge Clock);
    #2;
    preload = 1'b0;
    @(negedge Clock);
    chk("rst_gnt_held", {Gnt0, Gnt1, Busy}, 3'b000);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    @(posedge Clock);
    #2;
    chk("first_gnt_port0", {Gnt0, Gnt1}, 2'b10);
    chk("first_addr", Mem_Addr, 6'h2A);

    hit = 1'b0;
    for (k = 0; k < 20 && !hit; k++) begin
      @(negedge Clock);
      if (RValid0) begin
        hit = 1'b1;
        chk("read_2A_data", RData, 16'h1234);
        chk("read_2A_rv1", RValid1, 1'b0);
      end
    end
    chk("read_2A_seen", hit, 1'b1);

    hit = 1'b0;
    for (k = 0; k < 20 && !hit; k++) begin
      @(negedge Clock);
      if (RValid1) begin
        hit = 1'b1;
        chk("readback_05", RData, 16'hBEEF);
      end
    end
    chk("readback_05_seen", hit, 1'b1);
    wait_idle(100, "idle_after_basic");

    // Port 0 streams 64 reads; port 1 joins three cycles later.
    for (int i = 0; i < 64; i++) push(0, ADDR_W'(i), 1'b0, '0, 0);
    push(1, 6'h10, 1'b0, '0, 3);
    for (int i = 0; i < 3; i++) push(1, ADDR_W'(6'h11 + i), 1'b0, '0, 0);
    n0 = 0;
    hit = 1'b0;
    for (k = 0; k < 200 && !hit; k++) begin
      @(negedge Clock);
      if (Gnt1) hit = 1'b1;
      else if (Gnt0) n0++;
    end
    chk("burst_port1_served", hit, 1'b1);
    chk("burst_gnt0_beats", n0, RR ? MAX_BURST : 64);
    wait_idle(300, "idle_after_burst");

    // Reset while a read beat is being granted.
    for (int i = 0; i < 20; i++) push(0, ADDR_W'($urandom), 1'b0, '0, 0);
    hit = 1'b0;
    for (k = 0; k < 50 && !hit; k++) begin
      @(posedge Clock);
      #2;
      if (Gnt0 && !we_d[0]) hit = 1'b1;
    end
    chk("midrst_grant_found", hit, 1'b1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_rvalid0", RValid0, 1'b0);
    chk("midrst_busy", Busy, 1'b0);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_rvalid0_after", RValid0, 1'b0);
    wait_idle(200, "idle_after_midrst");

    // Random mixed traffic from both ports.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 250; i++) begin
        push(p, ADDR_W'($urandom_range(0, 63)), ($urandom_range(0, 2) == 0),
             DATA_W'($urandom),
             ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4)));
      end
    end
    wait_idle(20000, "idle_after_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
